// File: rtl/per2axi_req_sched.sv
// Round-robin scheduler sharing one per2axi request channel among NB_REQ requesters; one-hot IDs, per-requester outstanding caps.
// Latency: zero -- requester fields and grant pass combinationally; state, pointer, counters and err_o are registered.
// Backpressure: per_gnt_i low holds the selected request stable (HOLD); full requesters are skipped until a response retires.
// Option: define PER2AXI_SCHED_PRIO0_EN to give requester 0 fixed top priority without moving the round-robin pointer.
module per2axi_req_sched #(
    parameter int NB_REQ          = 4,
    parameter int PER_ADDR_WIDTH  = 32,
    parameter int PER_ID_WIDTH    = 5,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NB_REQ-1:0]                         req_i,
    input  logic [NB_REQ-1:0][PER_ADDR_WIDTH-1:0]     add_i,
    input  logic [NB_REQ-1:0]                         we_i,
    input  logic [NB_REQ-1:0][31:0]                   wdata_i,
    input  logic [NB_REQ-1:0][3:0]                    be_i,
    output logic [NB_REQ-1:0]                         gnt_o,
    output logic                                      per_req_o,
    output logic [PER_ADDR_WIDTH-1:0]                 per_add_o,
    output logic                                      per_we_o,
    output logic [31:0]                               per_wdata_o,
    output logic [3:0]                                per_be_o,
    output logic [PER_ID_WIDTH-1:0]                   per_id_o,
    input  logic                                      per_gnt_i,
    input  logic                                      rsp_valid_i,
    input  logic [PER_ID_WIDTH-1:0]                   rsp_id_i,
    output logic                                      busy_o,
    output logic                                      err_o
);

    localparam int SEL_W = $clog2(NB_REQ);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);
    localparam logic [PER_ID_WIDTH-1:0] LOW_MASK = PER_ID_WIDTH'((64'd1 << NB_REQ) - 64'd1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t               state;
    logic [SEL_W-1:0]     hold_sel;
    logic [SEL_W-1:0]     rr_ptr;
    logic [CNT_WIDTH-1:0] cnt [NB_REQ];

    logic [NB_REQ-1:0]    elig;
    logic [NB_REQ-1:0]    cnt_nz;
    logic                 arb_vld;
    logic [SEL_W-1:0]     arb_sel;
    logic [SEL_W-1:0]     scan_idx;
    logic [SEL_W-1:0]     cur_sel;
    logic                 issue;
    logic                 hold_drop;
    logic                 rsp_onehot;
    logic                 rsp_in_range;
    logic                 ret_ok;
    logic                 ret_zero;

    // Eligibility uses the registered count, so a same-cycle retire cannot unblock a full requester.
    always_comb begin
        elig   = '0;
        cnt_nz = '0;
        for (int k = 0; k < NB_REQ; k++) begin
            elig[k]   = req_i[k] && (cnt[k] < CNT_MAX);
            cnt_nz[k] = (cnt[k] != '0);
        end
    end

    // Arbitration: first eligible index at or after rr_ptr, wrapping; optional fixed priority for requester 0.
    always_comb begin
        arb_vld  = 1'b0;
        arb_sel  = '0;
        scan_idx = '0;
`ifdef PER2AXI_SCHED_PRIO0_EN
        if (elig[0]) begin
            arb_vld = 1'b1;
        end
`endif
        for (int i = 0; i < NB_REQ; i++) begin
            scan_idx = SEL_W'((int'(rr_ptr) + i) % NB_REQ);
            if (!arb_vld && elig[scan_idx]) begin
                arb_vld = 1'b1;
                arb_sel = scan_idx;
            end
        end
    end

    // Downstream request and field mux; HOLD keeps the registered selection and drops if its requester withdraws.
    always_comb begin
        cur_sel     = (state == HOLD) ? hold_sel : arb_sel;
        hold_drop   = (state == HOLD) && !req_i[hold_sel];
        per_req_o   = !rst_i && ((state == IDLE) ? arb_vld : req_i[hold_sel]);
        issue       = per_req_o && per_gnt_i;
        gnt_o       = issue ? (NB_REQ'(1) << cur_sel) : '0;
        per_id_o    = per_req_o ? (PER_ID_WIDTH'(1) << cur_sel) : '0;
        per_add_o   = per_req_o ? add_i[cur_sel]   : '0;
        per_we_o    = per_req_o ? we_i[cur_sel]    : 1'b0;
        per_wdata_o = per_req_o ? wdata_i[cur_sel] : '0;
        per_be_o    = per_req_o ? be_i[cur_sel]    : '0;
        busy_o      = |cnt_nz;
    end

    // Response decode: only a one-hot ID inside the requester range retires; a retire on an empty counter is an error.
    always_comb begin
        rsp_onehot   = (rsp_id_i != '0) && ((rsp_id_i & (rsp_id_i - 1'b1)) == '0);
        rsp_in_range = (rsp_id_i & ~LOW_MASK) == '0;
        ret_ok       = rsp_valid_i && rsp_onehot && rsp_in_range;
        ret_zero     = 1'b0;
        for (int k = 0; k < NB_REQ; k++) begin
            if (ret_ok && rsp_id_i[k] && !cnt_nz[k]) begin
                ret_zero = 1'b1;
            end
        end
    end

    // FSM, round-robin pointer, saturating outstanding counters and sticky error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            hold_sel <= '0;
            rr_ptr   <= '0;
            err_o    <= 1'b0;
            for (int k = 0; k < NB_REQ; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            if (state == IDLE) begin
                if (per_req_o && !per_gnt_i) begin
                    state    <= HOLD;
                    hold_sel <= arb_sel;
                end
            end else if (hold_drop || per_gnt_i) begin
                state <= IDLE;
            end

            if (issue) begin
`ifdef PER2AXI_SCHED_PRIO0_EN
                if (cur_sel != '0) begin
                    rr_ptr <= (cur_sel == SEL_W'(NB_REQ - 1)) ? '0 : cur_sel + 1'b1;
                end
`else
                rr_ptr <= (cur_sel == SEL_W'(NB_REQ - 1)) ? '0 : cur_sel + 1'b1;
`endif
            end

            for (int k = 0; k < NB_REQ; k++) begin
                if (issue && (cur_sel == SEL_W'(k)) && (cnt[k] < CNT_MAX)) begin
                    if (!(ret_ok && rsp_id_i[k] && cnt_nz[k])) begin
                        cnt[k] <= cnt[k] + 1'b1;
                    end
                end else if (ret_ok && rsp_id_i[k] && cnt_nz[k]) begin
                    cnt[k] <= cnt[k] - 1'b1;
                end
            end

            if (hold_drop || (rsp_valid_i && !ret_ok) || ret_zero) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_per2axi_req_sched.sv
// Directed bench for per2axi_req_sched: arbitration order, HOLD stability, caps, retire and error handling.
// Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle.
// The requester-0 priority case runs only when PER2AXI_SCHED_PRIO0_EN is defined.
module tb_per2axi_req_sched;

    logic              clk;
    logic              rst;
    logic [3:0]        req;
    logic [3:0][31:0]  add;
    logic [3:0]        we;
    logic [3:0][31:0]  wdata;
    logic [3:0][3:0]   be;
    logic [3:0]        gnt;
    logic              per_req;
    logic [31:0]       per_add;
    logic              per_we;
    logic [31:0]       per_wdata;
    logic [3:0]        per_be;
    logic [4:0]        per_id;
    logic              per_gnt;
    logic              rsp_valid;
    logic [4:0]        rsp_id;
    logic              busy;
    logic              err;

    int n_cmp = 0;
    int n_bad = 0;

    per2axi_req_sched dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .add_i       (add),
        .we_i        (we),
        .wdata_i     (wdata),
        .be_i        (be),
        .gnt_o       (gnt),
        .per_req_o   (per_req),
        .per_add_o   (per_add),
        .per_we_o    (per_we),
        .per_wdata_o (per_wdata),
        .per_be_o    (per_be),
        .per_id_o    (per_id),
        .per_gnt_i   (per_gnt),
        .rsp_valid_i (rsp_valid),
        .rsp_id_i    (rsp_id),
        .busy_o      (busy),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        per_gnt   = 1'b0;
        rsp_valid = 1'b0;
        rsp_id    = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            add[k]   = 32'h1000_0000 + 32'(k) * 32'h100;
            wdata[k] = 32'hD000_0000 + 32'(k);
            be[k]    = 4'(k + 1);
        end
        we = 4'b1010;
        do_reset();

        // Reset state
        settle();
        chk("rst_per_req", 32'(per_req), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // All four request with grant always high: 0,1,2,3 repeating, four each
        req = 4'b1111;
        per_gnt = 1'b1;
        for (int i = 0; i < 16; i++) begin
            settle();
            chk($sformatf("rr_gnt_%0d", i), 32'(gnt), 32'(4'b0001 << (i % 4)));
            chk($sformatf("rr_id_%0d", i), 32'(per_id), 32'(5'b00001 << (i % 4)));
            tick();
        end
        settle();
        chk("full_per_req", 32'(per_req), 32'd0);
        chk("full_gnt", 32'(gnt), 32'd0);
        chk("full_busy", 32'(busy), 32'd1);
        chk("full_err", 32'(err), 32'd0);

        // HOLD on requester 2 for 5 cycles; requester 0 joins but must not steal the slot
        do_reset();
        req = 4'b0100;
        per_gnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("hold_id_%0d", i), 32'(per_id), 32'h04);
            chk($sformatf("hold_add_%0d", i), per_add, 32'h1000_0200);
            chk($sformatf("hold_gnt_%0d", i), 32'(gnt), 32'd0);
            tick();
            req = 4'b0101;
        end
        per_gnt = 1'b1;
        settle();
        chk("hold_grant", 32'(gnt), 32'h4);
        chk("hold_wdata", per_wdata, 32'hD000_0002);
        chk("hold_be_we", {27'd0, per_we, per_be}, 32'h03);
        tick();
        req = 4'b0000;
        chk("hold_cnt2", 32'(dut.cnt[2]), 32'd1);
        settle();
        chk("hold_after_gnt", 32'(gnt), 32'd0);

        // Requester 1 full; retire and request in the same cycle grants only on the next
        do_reset();
        req = 4'b0010;
        per_gnt = 1'b1;
        repeat (4) tick();
        rsp_valid = 1'b1;
        rsp_id = 5'b00010;
        settle();
        chk("cap_no_gnt", 32'(gnt), 32'd0);
        chk("cap_no_req", 32'(per_req), 32'd0);
        tick();
        rsp_valid = 1'b0;
        rsp_id = '0;
        chk("cap_cnt_after_ret", 32'(dut.cnt[1]), 32'd3);
        settle();
        chk("cap_gnt_next", 32'(gnt), 32'h2);
        tick();
        chk("cap_cnt_back", 32'(dut.cnt[1]), 32'd4);
        chk("cap_err", 32'(err), 32'd0);

        // Issue and retire on requester 3 in one cycle
        do_reset();
        req = 4'b1000;
        per_gnt = 1'b1;
        repeat (2) tick();
        chk("sim_cnt3_pre", 32'(dut.cnt[3]), 32'd2);
        rsp_valid = 1'b1;
        rsp_id = 5'b01000;
        settle();
        chk("sim_gnt", 32'(gnt), 32'h8);
        tick();
        rsp_valid = 1'b0;
        req = 4'b0000;
        chk("sim_cnt3", 32'(dut.cnt[3]), 32'd2);

        // Issue on 0 while retiring on 3: both counters move
        req = 4'b0001;
        rsp_valid = 1'b1;
        rsp_id = 5'b01000;
        tick();
        rsp_valid = 1'b0;
        req = '0;
        chk("diff_cnt0", 32'(dut.cnt[0]), 32'd1);
        chk("diff_cnt3", 32'(dut.cnt[3]), 32'd1);
        chk("diff_err", 32'(err), 32'd0);

        // Error: non-one-hot ID
        do_reset();
        req = 4'b0011;
        per_gnt = 1'b1;
        repeat (2) tick();
        req = '0;
        rsp_valid = 1'b1;
        rsp_id = 5'b00011;
        tick();
        rsp_valid = 1'b0;
        chk("err_multi", 32'(err), 32'd1);
        chk("err_multi_cnt0", 32'(dut.cnt[0]), 32'd1);
        chk("err_multi_cnt1", 32'(dut.cnt[1]), 32'd1);
        repeat (3) tick();
        chk("err_sticky", 32'(err), 32'd1);

        // Error: retire on an empty counter right after reset
        do_reset();
        chk("err_cleared", 32'(err), 32'd0);
        rsp_valid = 1'b1;
        rsp_id = 5'b00100;
        tick();
        rsp_valid = 1'b0;
        chk("err_zero", 32'(err), 32'd1);
        chk("err_zero_cnt2", 32'(dut.cnt[2]), 32'd0);
        chk("err_zero_busy", 32'(busy), 32'd0);

        // Error: ID bit beyond the requester range
        do_reset();
        rsp_valid = 1'b1;
        rsp_id = 5'b10000;
        tick();
        rsp_valid = 1'b0;
        chk("err_range", 32'(err), 32'd1);

        // Error: requester withdraws during HOLD
        do_reset();
        req = 4'b0001;
        per_gnt = 1'b0;
        tick();
        req = 4'b0000;
        settle();
        chk("drop_per_req", 32'(per_req), 32'd0);
        per_gnt = 1'b1;
        settle();
        chk("drop_gnt", 32'(gnt), 32'd0);
        tick();
        per_gnt = 1'b0;
        chk("drop_err", 32'(err), 32'd1);
        chk("drop_cnt0", 32'(dut.cnt[0]), 32'd0);

`ifdef PER2AXI_SCHED_PRIO0_EN
        // Requester 0 wins every cycle until full, then requester 2
        do_reset();
        req = 4'b0101;
        per_gnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("prio_gnt0_%0d", i), 32'(gnt), 32'h1);
            tick();
        end
        settle();
        chk("prio_gnt2", 32'(gnt), 32'h4);
        tick();
        req = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/per2axi_req_sched.md
Name: per2axi_req_sched

Overview:
- Round-robin scheduler that shares one peripheral-to-AXI request channel among NB_REQ peripheral requesters.
- Sits between the cluster peripheral interconnect ports and the per2axi request channel.
- Tags each issued request with a one-hot ID derived from the requester index.
- Caps outstanding transactions per requester and retires them on returned AXI responses (R or B).

Parameters:
- NB_REQ, 4: number of requesters; 2..8; must be <= PER_ID_WIDTH.
- PER_ADDR_WIDTH, 32: peripheral address width.
- PER_ID_WIDTH, 5: width of the one-hot ID driven downstream.
- MAX_OUTSTANDING, 4: maximum in-flight transactions per requester; >= 1.
- CNT_WIDTH, $clog2(MAX_OUTSTANDING+1): width of the per-requester counter; do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  NB_REQ  per-requester request.
- add_i  in  NB_REQ x PER_ADDR_WIDTH  per-requester address.
- we_i  in  NB_REQ  per-requester write enable, passed through unchanged.
- wdata_i  in  NB_REQ x 32  per-requester write data.
- be_i  in  NB_REQ x 4  per-requester byte enables.
- gnt_o  out  NB_REQ  per-requester grant.
- per_req_o  out  1  downstream request.
- per_add_o  out  PER_ADDR_WIDTH  downstream address.
- per_we_o  out  1  downstream write enable.
- per_wdata_o  out  32  downstream write data.
- per_be_o  out  4  downstream byte enables.
- per_id_o  out  PER_ID_WIDTH  downstream ID, one-hot of the selected requester index.
- per_gnt_i  in  1  downstream grant.
- rsp_valid_i  in  1  response retired (R or B handshake).
- rsp_id_i  in  PER_ID_WIDTH  one-hot ID of the retired response.
- busy_o  out  1  at least one counter is non-zero.
- err_o  out  1  sticky protocol error.

Behaviour:
- Eligibility: requester k is eligible when req_i[k]=1 and cnt[k] < MAX_OUTSTANDING.
- States:
  - IDLE: no pending downstream request.
  - HOLD: a request is presented downstream but not yet granted.
- IDLE:
  - If any requester is eligible, select sel = first eligible index starting at rr_ptr and wrapping modulo NB_REQ.
  - Drive per_req_o=1 and mux requester sel's fields to the outputs combinationally.
  - per_id_o = 1<<sel.
  - If per_gnt_i=1 in the same cycle: issue; stay IDLE.
  - Otherwise: register sel, go to HOLD.
- HOLD:
  - Keep the registered sel; per_req_o=1; outputs stay stable and the selection is not re-arbitrated.
  - When per_gnt_i=1: issue; go to IDLE.
  - If req_i[sel] drops while in HOLD: set err_o, drop per_req_o, go to IDLE.
- Issue (one cycle):
  - gnt_o[sel]=1, all other gnt_o bits 0, so gnt_o is one-hot or zero.
  - rr_ptr <= (sel+1) mod NB_REQ.
  - cnt[sel] increments.
  - Zero-latency path: requester to downstream is combinational; grant returns in the same cycle as per_gnt_i.
- Retire:
  - When rsp_valid_i=1, cnt[k] decrements for the k with rsp_id_i[k]=1.
  - If rsp_id_i is not one-hot, or has a bit at index >= NB_REQ: set err_o and change no counter.
  - If the retire targets cnt[k]=0: set err_o and leave the counter at 0.
- Simultaneous issue and retire on the same requester: counter unchanged. On different requesters: both counters update.
- Full requester (cnt = MAX_OUTSTANDING): skipped by arbitration; its gnt_o stays 0 until a retire. A retire and request in the same cycle do not make it eligible until the next cycle, because eligibility uses the registered count.
- Counters saturate: never exceed MAX_OUTSTANDING, never wrap below 0.
- busy_o = OR of (cnt[k] != 0).
- Reset values: state=IDLE, rr_ptr=0, all cnt=0, err_o=0. All outputs 0, including per_req_o, gnt_o and busy_o.
- Reset mid-operation: a HOLD request is dropped and all outstanding state is cleared. Responses arriving after reset are handled as errors (cnt=0 case).
- err_o clears only on rst_i.

Optional Feature:
- Macro: PER2AXI_SCHED_PRIO0_EN.
- Defined: requester 0 has fixed highest priority whenever eligible in IDLE. Remaining requesters use round-robin from rr_ptr. A grant to requester 0 does not move rr_ptr.
- Undefined: pure round-robin over all NB_REQ requesters, as above.

Test Plan:
- Reset, then all 4 requesters request continuously with per_gnt_i=1 and no responses.
  - Grants in order 0,1,2,3,0,1,2,3.
  - All four requesters are blocked after 4 grants each; per_req_o=0; busy_o=1.
- Requester 2 requests with per_gnt_i=0 for 5 cycles, then 1.
  - State HOLD; per_id_o=5'b00100 with stable address/data.
  - gnt_o=4'b0100 only in the grant cycle; cnt[2]=1.
- Requester 1 at cnt=4; rsp_valid_i with rsp_id_i=5'b00010 while req_i[1]=1.
  - No grant that cycle; grant to 1 the next cycle; cnt[1] returns to 4.
- Issue to requester 3 and retire ID 5'b01000 in the same cycle with cnt[3]=2 -> cnt[3] stays 2.
- Error cases, each setting err_o=1 and leaving counters unchanged:
  - rsp_valid_i with rsp_id_i=5'b00011.
  - A retire on a zero counter.
  - Requester dropping its request during HOLD.
  - err_o holds until rst_i.
- With PER2AXI_SCHED_PRIO0_EN: requesters 0 and 2 request continuously -> requester 0 granted every cycle until cnt[0]=4, then requester 2 granted.
